pwm_bank: RTL and testbench
===========================

PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter NCH, default 4, number of PWM channels (1..16).
REQ-002 SHALL have parameter CW, default 13, period/width counter width.
REQ-003 SHALL have parameter PSW, default 5, prescaler width.
REQ-004 SHALL have parameter DT, default 3, dead time in clk cycles (used only under REQ-029).
REQ-005 SHALL have ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  global run enable.
- load  in  1  one-cycle strobe: latch presc/period, restart counters.
- presc  in  PSW  prescale value (tick every presc+1 enabled cycles).
- period  in  CW  period value (period+1 ticks per PWM period).
- wr_valid  in  1  width-write request.
- wr_ready  out  1  width-write accept.
- wr_ch  in  4  target channel index.
- wr_width  in  CW  requested high time in ticks.
- wr_err  out  1  one-cycle pulse: accepted write had wr_ch >= NCH.
- tick  out  1  one-cycle prescaler pulse.
- period_start  out  1  one-cycle pulse at period wrap.
- cnt  out  CW  current period counter.
- pwm_out  out  NCH  per-channel PWM level.
- pwm_set  out  NCH  one-cycle pulse on pwm_out rise.
- pwm_reset  out  NCH  one-cycle pulse on pwm_out fall.

Function
REQ-006 On load, SHALL latch presc and period into internal registers, clear prescaler count and cnt, copy all shadow widths into active widths; load overrides en.
REQ-007 While en=1, prescaler count SHALL increment each cycle; when equal to latched presc, tick SHALL pulse that cycle and count SHALL return to 0; latched presc=0 gives tick every enabled cycle.
REQ-008 On each tick, cnt SHALL increment; when cnt equals latched period, cnt SHALL wrap to 0 and period_start SHALL pulse in that cycle.
REQ-009 Latched period=0 SHALL give period_start on every tick with cnt held at 0.
REQ-010 While en=0, prescaler and cnt SHALL hold; tick and period_start SHALL stay 0.
REQ-011 A write SHALL be accepted in a cycle with wr_valid=1 and wr_ready=1; wr_ready SHALL be 0 during load and in any cycle where period_start=1, else 1.
REQ-012 Accepted write with wr_ch<NCH SHALL update shadow[wr_ch] next edge; with wr_ch>=NCH SHALL discard data and pulse wr_err next cycle.
REQ-013 On period_start, SHALL copy every shadow width to its active width; mid-period writes SHALL NOT alter the current period.
REQ-014 pwm_out[i] SHALL be registered, equal to (en and cnt<active[i]) one cycle after the cnt value is present.
REQ-015 active[i]=0 SHALL hold pwm_out[i] low; active[i]>period SHALL hold it high while en=1.
REQ-016 pwm_set[i]/pwm_reset[i] SHALL pulse for one cycle, one cycle after pwm_out[i] rises/falls, including the fall forced by en=0.
REQ-017 Channels SHALL update simultaneously from one shared cnt; no per-channel phase skew.

Reset
REQ-018 reset=0 SHALL asynchronously force: prescaler count, cnt, latched presc, latched period, all shadow and active widths to 0.
REQ-019 During reset, pwm_out, pwm_set, pwm_reset, tick, period_start, wr_err, wr_ready SHALL be 0.
REQ-020 Reset deassertion SHALL be sampled synchronously; first write accept no earlier than the first clk edge after release.
REQ-021 Reset mid-period SHALL discard pending shadow values; no set/reset pulses SHALL be generated by the reset itself.

Configuration
REQ-029 Macro PWM_BANK_DEADTIME_EN SHALL add output pwm_out_n [NCH-1:0]; without it the port and dead-time logic SHALL be absent.
REQ-030 With it, pwm_out_n[i] SHALL be high only after pwm_out[i] has been low for DT consecutive cycles and SHALL fall in the same cycle pwm_out[i] rises; pwm_out[i] and pwm_out_n[i] SHALL never both be high; reset value 0.

Verification
REQ-040 presc=4, period=9, load, en=1 -> tick every 5 cycles, period_start every 50 cycles, cnt 0..9 wrap.
REQ-041 Write ch0=3, ch1=0, ch2=12 before load -> ch0 high 3 ticks of 10, ch1 always low, ch2 always high; pwm_set/pwm_reset one-cycle pulses at ch0 edges only.
REQ-042 Write ch0=7 at cnt=2 of period with active 3 -> current period keeps width 3, next period width 7; write attempted on period_start cycle sees wr_ready=0 and lands one cycle later.
REQ-043 wr_ch=5 with NCH=4 -> write accepted, wr_err pulses once, no shadow changes.
REQ-044 en dropped while pwm_out high -> pwm_out low next cycle, pwm_reset pulse, cnt frozen; en restored -> resumes from frozen cnt.
REQ-045 PWM_BANK_DEADTIME_EN defined, DT=3, presc=0, width 4, period 9 -> pwm_out_n rises 3 cycles after pwm_out falls, falls with pwm_out rise, no overlap in 1000 cycles; reset asserted mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/pwm_bank.sv
// pwm_bank: NCH PWM channels sharing one prescaler and one period counter.
// Each channel has a shadow width, written through a valid/ready port, and an
// active width that is reloaded from the shadow at load and at every period
// wrap. That way a width never changes in the middle of a period.
// Optional feature: define PWM_BANK_DEADTIME_EN to add complementary outputs
// pwm_out_n with DT cycles of dead time after each falling edge of pwm_out.
module pwm_bank #(
  parameter int NCH = 4,   // number of channels, 1..16
  parameter int CW  = 13,  // period / width counter width
  parameter int PSW = 5,   // prescaler width
  parameter int DT  = 3    // dead time in clk cycles (PWM_BANK_DEADTIME_EN only)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           load,
  input  logic [PSW-1:0] presc,
  input  logic [CW-1:0]  period,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic [3:0]     wr_ch,
  input  logic [CW-1:0]  wr_width,
  output logic           wr_err,
  output logic           tick,
  output logic           period_start,
  output logic [CW-1:0]  cnt,
  output logic [NCH-1:0] pwm_out,
  output logic [NCH-1:0] pwm_set,
  output logic [NCH-1:0] pwm_reset
`ifdef PWM_BANK_DEADTIME_EN
  ,
  output logic [NCH-1:0] pwm_out_n
`endif
);

  // Channel count as a 5-bit value, so it can be compared against the 4-bit
  // channel index without a width mismatch (NCH = 16 still fits).
  localparam logic [4:0] NCH_W = 5'(NCH);

  // Configuration latched at load.
  logic [PSW-1:0] r_presc;
  logic [CW-1:0]  r_period;

  // Timebase.
  logic [PSW-1:0] r_pcnt;
  logic [CW-1:0]  r_cnt;

  // Goes high on the first edge after reset is released. It keeps the
  // combinational strobes low while reset is asserted, and it makes the first
  // write accept land no earlier than that edge.
  logic           r_alive;

  // Width storage.
  logic [CW-1:0]  r_shadow [NCH];
  logic [CW-1:0]  r_active [NCH];

  // Output stage.
  logic [NCH-1:0] r_out;
  logic [NCH-1:0] r_out_d;
  logic [NCH-1:0] r_set;
  logic [NCH-1:0] r_reset;
  logic           r_err;

  // Combinational control.
  logic           w_run;
  logic           w_tick;
  logic           w_wrap;
  logic           w_pstart;
  logic           w_ready;
  logic           w_accept;
  logic           w_ch_ok;
  logic           w_copy;
  logic [NCH-1:0] w_out_next;

  // Timebase strobes, write handshake and the active-width reload condition.
  // load has priority: while it is high the timebase does not advance.
  assign w_run    = r_alive & en & ~load;
  assign w_tick   = w_run & (r_pcnt == r_presc);
  assign w_wrap   = (r_cnt == r_period);
  assign w_pstart = w_tick & w_wrap;
  // Writes are refused in reload cycles, so a shadow update can never race
  // the shadow-to-active copy.
  assign w_ready  = r_alive & ~load & ~w_pstart;
  assign w_accept = wr_valid & w_ready;
  assign w_ch_ok  = ({1'b0, wr_ch} < NCH_W);
  assign w_copy   = load | w_pstart;

  // Next PWM level of every channel, all taken from the one shared counter.
  always_comb begin
    // NOTE: every bit gets a value on every pass through this block, so no
    // latch can be inferred.
    w_out_next = '0;
    for (int i = 0; i < NCH; i++) begin
      w_out_next[i] = en & (r_cnt < r_active[i]);
    end
  end

  // Reset-release flag.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: registers are written with non-blocking assignments, so every
    // block samples the values from before this edge.
    if (!reset) r_alive <= 1'b0;
    else        r_alive <= 1'b1;
  end

  // Configuration latch, prescaler and period counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc  <= '0;
      r_period <= '0;
      r_pcnt   <= '0;
      r_cnt    <= '0;
    end else if (load) begin
      r_presc  <= presc;
      r_period <= period;
      r_pcnt   <= '0;
      r_cnt    <= '0;
    end else if (w_run) begin
      if (w_tick) begin
        r_pcnt <= '0;
        r_cnt  <= w_wrap ? '0 : r_cnt + CW'(1);
      end else begin
        r_pcnt <= r_pcnt + PSW'(1);
      end
    end
  end

  // Shadow widths take accepted writes. Active widths reload at load and at
  // period wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the width stores are small flop arrays rather than RAM, so they
      // are cleared by the async reset. This discards any pending shadow value.
      for (int i = 0; i < NCH; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_accept && (wr_ch == 4'(i))) r_shadow[i] <= wr_width;
        if (w_copy)                       r_active[i] <= r_shadow[i];
      end
    end
  end

  // Error pulse for an accepted write to a channel that does not exist.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_err <= 1'b0;
    else        r_err <= w_accept & ~w_ch_ok;
  end

  // Registered PWM levels and edge pulses one cycle after each edge.
  // Reset clears both the level and its delayed copy, so reset never produces
  // a pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out   <= '0;
      r_out_d <= '0;
      r_set   <= '0;
      r_reset <= '0;
    end else begin
      r_out   <= w_out_next;
      r_out_d <= r_out;
      r_set   <= r_out & ~r_out_d;
      r_reset <= ~r_out & r_out_d;
    end
  end

`ifdef PWM_BANK_DEADTIME_EN
  // Low-run counter wide enough to hold DT; it saturates there.
  localparam int LW = $clog2(DT + 2);

  logic [LW-1:0]  r_lowc [NCH];
  logic [LW-1:0]  w_lowc_next [NCH];
  logic [NCH-1:0] r_out_n;
  logic [NCH-1:0] w_out_n_next;

  // Count consecutive low cycles of each channel. The complement is allowed
  // high once DT low cycles have passed, and is forced low in the same edge
  // that raises pwm_out, so the two outputs never overlap.
  always_comb begin
    w_out_n_next = '0;
    for (int i = 0; i < NCH; i++) begin
      w_lowc_next[i] = r_lowc[i];
      if (w_out_next[i] || r_out[i])  w_lowc_next[i] = '0;
      else if (r_lowc[i] < LW'(DT))   w_lowc_next[i] = r_lowc[i] + LW'(1);
      w_out_n_next[i] = ~w_out_next[i] & (w_lowc_next[i] >= LW'(DT));
    end
  end

  // Complementary output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_n <= '0;
      for (int i = 0; i < NCH; i++) r_lowc[i] <= '0;
    end else begin
      r_out_n <= w_out_n_next;
      for (int i = 0; i < NCH; i++) r_lowc[i] <= w_lowc_next[i];
    end
  end

  assign pwm_out_n = r_out_n;
`endif

  assign wr_ready     = w_ready;
  assign wr_err       = r_err;
  assign tick         = w_tick;
  assign period_start = w_pstart;
  assign cnt          = r_cnt;
  assign pwm_out      = r_out;
  assign pwm_set      = r_set;
  assign pwm_reset    = r_reset;

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: self-checking bench for pwm_bank. A behavioural model derives
// tick, cnt and period_start with modular arithmetic on the enabled-cycle and
// tick counts since the last load. PWM levels and edge pulses come from the
// width rules and the level history. Directed phases come first, then
// randomized traffic and an asynchronous reset in the middle of a run.
module tb_pwm_bank;
  localparam int NCH = 4;
  localparam int CW  = 13;
  localparam int PSW = 5;
  localparam int DT  = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic           load;
  logic [PSW-1:0] presc;
  logic [CW-1:0]  period;
  logic           wr_valid;
  logic           wr_ready;
  logic [3:0]     wr_ch;
  logic [CW-1:0]  wr_width;
  logic           wr_err;
  logic           tick;
  logic           period_start;
  logic [CW-1:0]  cnt;
  logic [NCH-1:0] pwm_out;
  logic [NCH-1:0] pwm_set;
  logic [NCH-1:0] pwm_reset;
`ifdef PWM_BANK_DEADTIME_EN
  logic [NCH-1:0] pwm_out_n;
`endif

  always #5 clk = ~clk;

  pwm_bank #(.NCH(NCH), .CW(CW), .PSW(PSW), .DT(DT)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .load         (load),
    .presc        (presc),
    .period       (period),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_ch        (wr_ch),
    .wr_width     (wr_width),
    .wr_err       (wr_err),
    .tick         (tick),
    .period_start (period_start),
    .cnt          (cnt),
    .pwm_out      (pwm_out),
    .pwm_set      (pwm_set),
    .pwm_reset    (pwm_reset)
`ifdef PWM_BANK_DEADTIME_EN
    ,
    .pwm_out_n    (pwm_out_n)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  int             m_presc, m_period;
  int             m_en_cnt;          // enabled, non-load cycles since load
  int             m_ticks;           // ticks since load
  int             m_shadow [NCH];
  int             m_active [NCH];
  int             m_lowrun [NCH];    // consecutive earlier cycles with pwm_out low
  logic [NCH-1:0] m_out, m_out_d1, m_out_d2;
  bit             m_err, m_alive;

  // Observations from the most recent cycle, for the directed tallies.
  bit             g_tick, g_ps;
  logic [NCH-1:0] g_out, g_set, g_rst;

  task automatic model_reset();
    m_presc = 0; m_period = 0; m_en_cnt = 0; m_ticks = 0;
    for (int i = 0; i < NCH; i++) begin
      m_shadow[i] = 0; m_active[i] = 0; m_lowrun[i] = 0;
    end
    m_out = '0; m_out_d1 = '0; m_out_d2 = '0;
    m_err = 1'b0; m_alive = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tick"},      32'(tick),         32'd0);
    check({tag, "_pstart"},    32'(period_start), 32'd0);
    check({tag, "_wr_ready"},  32'(wr_ready),     32'd0);
    check({tag, "_wr_err"},    32'(wr_err),       32'd0);
    check({tag, "_cnt"},       32'(cnt),          32'd0);
    check({tag, "_pwm_out"},   32'(pwm_out),      32'd0);
    check({tag, "_pwm_set"},   32'(pwm_set),      32'd0);
    check({tag, "_pwm_reset"}, 32'(pwm_reset),    32'd0);
`ifdef PWM_BANK_DEADTIME_EN
    check({tag, "_pwm_out_n"}, 32'(pwm_out_n),    32'd0);
`endif
  endtask

  // One clock cycle. The caller must be at a falling edge. The task drives
  // the inputs, checks every output against the model, advances the model
  // across the next rising edge, and returns at the following falling edge.
  task automatic cycle(input bit i_en, input bit i_load, input int i_presc,
                       input int i_period, input bit i_wv, input int i_wch,
                       input int i_ww, output bit accepted);
    bit             e_tick, e_ps, e_rdy;
    int             e_cnt;
    logic [NCH-1:0] e_next, e_n;
    en       = i_en;
    load     = i_load;
    presc    = PSW'(i_presc);
    period   = CW'(i_period);
    wr_valid = i_wv;
    wr_ch    = 4'(i_wch);
    wr_width = CW'(i_ww);
    #1;
    e_tick = m_alive && i_en && !i_load && ((m_en_cnt % (m_presc + 1)) == m_presc);
    e_cnt  = m_ticks % (m_period + 1);
    e_ps   = e_tick && (e_cnt == m_period);
    e_rdy  = m_alive && !i_load && !e_ps;
    for (int i = 0; i < NCH; i++) e_n[i] = !m_out[i] && (m_lowrun[i] >= DT);

    check("tick",      32'(tick),         32'(e_tick));
    check("pstart",    32'(period_start), 32'(e_ps));
    check("cnt",       32'(cnt),          32'(e_cnt));
    check("wr_ready",  32'(wr_ready),     32'(e_rdy));
    check("wr_err",    32'(wr_err),       32'(m_err));
    check("pwm_out",   32'(pwm_out),      32'(m_out));
    check("pwm_set",   32'(pwm_set),      32'(m_out_d1 & ~m_out_d2));
    check("pwm_reset", 32'(pwm_reset),    32'(~m_out_d1 & m_out_d2));
`ifdef PWM_BANK_DEADTIME_EN
    check("pwm_out_n", 32'(pwm_out_n),    32'(e_n));
    check("overlap",   32'(pwm_out & pwm_out_n), 32'd0);
`endif
    g_tick = tick; g_ps = period_start; g_out = pwm_out; g_set = pwm_set; g_rst = pwm_reset;

    // Advance the model to the state after the next rising edge.
    for (int i = 0; i < NCH; i++) e_next[i] = i_en && (e_cnt < m_active[i]);
    accepted = i_wv && e_rdy;
    if (i_load) begin
      m_presc = i_presc; m_period = i_period; m_en_cnt = 0; m_ticks = 0;
      for (int i = 0; i < NCH; i++) m_active[i] = m_shadow[i];
    end else if (m_alive && i_en) begin
      m_en_cnt++;
      if (e_tick) m_ticks++;
      if (e_ps) for (int i = 0; i < NCH; i++) m_active[i] = m_shadow[i];
    end
    m_err = accepted && (i_wch >= NCH);
    if (accepted && i_wch < NCH) m_shadow[i_wch] = i_ww;
    for (int i = 0; i < NCH; i++) m_lowrun[i] = m_out[i] ? 0 : m_lowrun[i] + 1;
    m_out_d2 = m_out_d1;
    m_out_d1 = m_out;
    m_out    = e_next;
    m_alive  = 1'b1;
    @(negedge clk);
  endtask

  // Hold a write request until it is accepted, at most 8 cycles.
  task automatic send(input bit i_en, input int ch, input int w);
    bit acc = 1'b0;
    for (int k = 0; k < 8 && !acc; k++) cycle(i_en, 1'b0, 0, 0, 1'b1, ch, w, acc);
    check("send_accepted", 32'(acc), 32'd1);
  endtask

  initial begin
    bit acc;
    bit pend;
    int pch, pw;
    int n_tick, n_ps, n_hi0, n_hi1, n_hi2, n_set0, n_rst0, n_rst2;

    reset = 1'b0; en = 1'b0; load = 1'b0; presc = '0; period = '0;
    wr_valid = 1'b0; wr_ch = '0; wr_width = '0;
    model_reset();
    #3;
    check_all_zero("rst_before_edge");
    en = 1'b1; wr_valid = 1'b1;   // reset must win over active inputs
    repeat (2) @(negedge clk);
    check_all_zero("rst_held");
    en = 1'b0; wr_valid = 1'b0;

    // Release reset. No write may be accepted before the first edge.
    reset = 1'b1;
    cycle(1'b0, 1'b0, 0, 0, 1'b1, 3, 9, acc);
    check("first_cycle_no_accept", 32'(acc), 32'd0);
    cycle(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, acc);

    // Program widths, then load presc=4, period=9.
    send(1'b0, 0, 3);
    send(1'b0, 1, 0);
    send(1'b0, 2, 12);
    send(1'b0, 3, 5);
    cycle(1'b1, 1'b1, 4, 9, 1'b0, 0, 0, acc);   // load cycle L

    n_tick = 0; n_ps = 0; n_hi0 = 0; n_hi1 = 0; n_hi2 = 0;
    n_set0 = 0; n_rst0 = 0; n_rst2 = 0;
    for (int k = 1; k <= 101; k++) begin       // cycles L+1 .. L+101
      cycle(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, acc);
      if (k <= 100) begin
        n_tick += int'(g_tick);
        n_ps   += int'(g_ps);
      end
      if (k >= 2) begin
        n_hi0  += int'(g_out[0]);
        n_hi1  += int'(g_out[1]);
        n_hi2  += int'(g_out[2]);
        n_set0 += int'(g_set[0]);
        n_rst0 += int'(g_rst[0]);
        n_rst2 += int'(g_rst[2]);
      end
    end
    check("dir_ticks_100cyc",  32'(n_tick), 32'd20);
    check("dir_pstart_100cyc", 32'(n_ps),   32'd2);
    check("dir_ch0_high",      32'(n_hi0),  32'd30);
    check("dir_ch1_high",      32'(n_hi1),  32'd0);
    check("dir_ch2_high",      32'(n_hi2),  32'd100);
    check("dir_ch0_sets",      32'(n_set0), 32'd2);
    check("dir_ch0_resets",    32'(n_rst0), 32'd2);
    check("dir_ch2_resets",    32'(n_rst2), 32'd0);

    // Mid-period write: ch0=7 at cnt=2 must only take effect next period.
    for (int k = 0; k < 60; k++) begin
      if ((m_ticks % (m_period + 1)) == 2) break;
      cycle(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, acc);
    end
    send(1'b1, 0, 7);
    // Write attempted in a period_start cycle is held off by one cycle.
    for (int k = 0; k < 60; k++) begin
      if ((m_ticks % (m_period + 1)) == m_period && (m_en_cnt % (m_presc + 1)) == m_presc) break;
      cycle(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, acc);
    end
    cycle(1'b1, 1'b0, 0, 0, 1'b1, 1, 2, acc);
    check("pstart_write_refused", 32'(acc), 32'd0);
    cycle(1'b1, 1'b0, 0, 0, 1'b1, 1, 2, acc);
    check("pstart_write_next", 32'(acc), 32'd1);

    // Write to a nonexistent channel.
    send(1'b1, 5, 11);
    check("bad_ch_wr_err", 32'(wr_err), 32'd1);
    cycle(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, acc);
    repeat (60) cycle(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, acc);

    // Randomized traffic with en drops, reloads and an async reset mid-run.
    pend = 1'b0; pch = 0; pw = 0;
    for (int k = 0; k < 3000; k++) begin
      bit ld, e;
      ld = ($urandom_range(0, 99) < 2);
      e  = ($urandom_range(0, 9) != 0);
      if (!pend && $urandom_range(0, 3) == 0) begin
        pend = 1'b1;
        pch  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(NCH, 15))
                                           : int'($urandom_range(0, NCH - 1));
        pw   = $urandom_range(0, 14);
      end
      cycle(e, ld, $urandom_range(0, 3), $urandom_range(0, 11), pend, pch, pw, acc);
      if (acc) pend = 1'b0;
      if (k == 1500) begin
        #2 reset = 1'b0;
        #1 check_all_zero("rst_midrun");
        model_reset();
        pend = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
